mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_prio.sv | 49 ++++
 rtl/mem_arb.sv | 128 ++++++++++++
 tb/tb_mem_arb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_arb fetch/data arbiter: FSM state and requester identity.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data requesters; data has priority unless the
// optional starve guard (MEM_ARB_STARVE_GUARD_EN) forces a fetch after STARVE_MAX data grants.
module mem_arb_prio
    import mem_arb_pkg::*;
`ifdef MEM_ARB_STARVE_GUARD_EN
#(
    parameter int STARVE_MAX = 4
)
`endif
(
`ifdef MEM_ARB_STARVE_GUARD_EN
    input  logic    clk,
    input  logic    rst_n,
`endif
    input  logic    arb_en,
    input  logic    if_req,
    input  logic    d_req,
    output logic    grant,
    output req_id_e winner
);

    assign grant = arb_en && (if_req || d_req);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic             starved;

    assign starved = (starve_cnt_reg == CNT_W'(STARVE_MAX));
    assign winner  = (d_req && !(if_req && starved)) ? REQ_D : REQ_IF;

    // Counts only data grants that actually made a waiting fetch wait longer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
        end else if (!if_req) begin
            starve_cnt_reg <= '0;
        end else if (grant && (winner == REQ_IF)) begin
            starve_cnt_reg <= '0;
        end else if (grant && (winner == REQ_D) && !starved) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end
`else
    assign winner = d_req ? REQ_D : REQ_IF;
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter in front of a single-port memory: IDLE/BUSY FSM plus captured command
// and response registers. Optional starve guard enabled by MEM_ARB_STARVE_GUARD_EN.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_rd,
    output logic          m_wr,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          busy
);

    if (STARVE_MAX < 1) begin : g_starve_max_check
        $error("mem_arb: STARVE_MAX must be at least 1");
    end

    state_e        state_reg;
    req_id_e       id_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic          if_rvalid_reg;
    logic          d_rvalid_reg;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] d_rdata_reg;

    logic          grant;
    req_id_e       winner;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk    (clk),
        .rst_n  (rst_n),
`else
    mem_arb_prio u_prio (
`endif
        .arb_en (state_reg == IDLE),
        .if_req (if_req),
        .d_req  (d_req),
        .grant  (grant),
        .winner (winner)
    );

    assign if_gnt    = grant && (winner == REQ_IF);
    assign d_gnt     = grant && (winner == REQ_D);
    assign busy      = (state_reg == BUSY);
    assign m_rd      = busy && !we_reg;
    assign m_wr      = busy && we_reg;
    assign m_addr    = addr_reg;
    assign m_wdata   = wdata_reg;
    assign if_rvalid = if_rvalid_reg;
    assign d_rvalid  = d_rvalid_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            id_reg        <= REQ_IF;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
        end else begin
            if_rvalid_reg <= 1'b0;
            d_rvalid_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        state_reg <= BUSY;
                        id_reg    <= winner;
                        if (winner == REQ_D) begin
                            addr_reg  <= d_addr;
                            wdata_reg <= d_wdata;
                            we_reg    <= d_we;
                        end else begin
                            addr_reg  <= if_addr;
                            wdata_reg <= '0;
                            we_reg    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    // Response goes out the cycle after m_ready, as the arbiter is already back in IDLE.
                    if (m_ready) begin
                        state_reg <= IDLE;
                        if (id_reg == REQ_IF) begin
                            if_rvalid_reg <= 1'b1;
                            if_rdata_reg  <= m_rdata;
                        end else begin
                            d_rvalid_reg <= 1'b1;
                            if (!we_reg) begin
                                d_rdata_reg <= m_rdata;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed and randomized checks of mem_arb against a transaction-level model of the arbiter.
module tb_mem_arb;

    localparam int DW         = 32;
    localparam int AW         = 32;
    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rd, m_wr;
    logic [DW-1:0] m_rdata;
    logic          m_ready;
    logic          busy;

    always #5 clk = ~clk;

    mem_arb #(
        .DW         (DW),
        .AW         (AW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rd      (m_rd),
        .m_wr      (m_wr),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding transaction, pending response, last returned data.
    bit            out_valid;
    bit            txn_d;
    bit            txn_we;
    logic [AW-1:0] txn_addr;
    logic [DW-1:0] txn_wdata;
    int            pend;
    logic [DW-1:0] last_if;
    logic [DW-1:0] last_d;
    int            streak;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        out_valid = 0;
        txn_d     = 0;
        txn_we    = 0;
        txn_addr  = '0;
        txn_wdata = '0;
        pend      = 0;
        last_if   = '0;
        last_d    = '0;
        streak    = 0;
    endtask

    task automatic check_cycle();
        bit eif, ed;
        eif = 0;
        ed  = 0;
        if (!out_valid) begin
            if (if_req && (!d_req || (GUARD && streak == STARVE_MAX))) eif = 1;
            else if (d_req) ed = 1;
        end
        chk("if_gnt", if_gnt, eif);
        chk("d_gnt", d_gnt, ed);
        chk("busy", busy, out_valid);
        chk("m_rd", m_rd, out_valid && !txn_we);
        chk("m_wr", m_wr, out_valid && txn_we);
        if (out_valid) begin
            chk("m_addr", m_addr, txn_addr);
            if (txn_we) chk("m_wdata", m_wdata, txn_wdata);
        end
        chk("if_rvalid", if_rvalid, pend == 1);
        chk("d_rvalid", d_rvalid, pend == 2);
        chk("if_rdata", if_rdata, last_if);
        chk("d_rdata", d_rdata, last_d);

        pend = 0;
        if (out_valid && m_ready) begin
            if (!txn_d) last_if = m_rdata;
            else if (!txn_we) last_d = m_rdata;
            pend      = txn_d ? 2 : 1;
            out_valid = 0;
        end else if (eif) begin
            out_valid = 1;
            txn_d     = 0;
            txn_we    = 0;
            txn_addr  = if_addr;
        end else if (ed) begin
            out_valid = 1;
            txn_d     = 1;
            txn_we    = d_we;
            txn_addr  = d_addr;
            txn_wdata = d_wdata;
        end
        if (!if_req || eif) streak = 0;
        else if (ed && streak < STARVE_MAX) streak++;
    endtask

    task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd,
                        input logic rdy, input logic [DW-1:0] rd);
        @(posedge clk);
        #1;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
        m_ready = rdy;
        m_rdata = rd;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input logic rdy);
        step(0, '0, 0, 0, '0, '0, rdy, $urandom);
    endtask

    initial begin
        int  n_fetch;
        int  exp_fetch;
        bit  ir, dr;

        rst_n   = 0;
        if_req  = 0;
        if_addr = '0;
        d_req   = 0;
        d_we    = 0;
        d_addr  = '0;
        d_wdata = '0;
        m_ready = 0;
        m_rdata = '0;
        model_reset();
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_m_rd", m_rd, 0);
        chk("rst_m_wr", m_wr, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle(0);

        // Single fetch read with one-cycle memory latency.
        step(1, 32'h40, 0, 0, '0, '0, 0, '0);
        chk("t1_if_gnt_c0", if_gnt, 1);
        step(0, '0, 0, 0, '0, '0, 1, 32'hDEADBEEF);
        chk("t1_m_rd_c1", m_rd, 1);
        chk("t1_m_addr_c1", m_addr, 32'h40);
        idle(0);
        chk("t1_if_rvalid_c2", if_rvalid, 1);
        chk("t1_if_rdata_c2", if_rdata, 32'hDEADBEEF);

        // Simultaneous requests: data write wins, fetch granted on the rvalid cycle.
        step(1, 32'h80, 1, 1, 32'h100, 32'h12345678, 0, '0);
        chk("t2_d_gnt", d_gnt, 1);
        chk("t2_if_gnt_low", if_gnt, 0);
        step(1, 32'h80, 0, 0, '0, '0, 1, 32'h0BADF00D);
        chk("t2_m_wr", m_wr, 1);
        chk("t2_m_addr", m_addr, 32'h100);
        chk("t2_m_wdata", m_wdata, 32'h12345678);
        step(1, 32'h80, 0, 0, '0, '0, 0, '0);
        chk("t2_d_rvalid", d_rvalid, 1);
        chk("t2_if_gnt_on_rvalid", if_gnt, 1);
        chk("t2_d_rdata_hold", d_rdata, 0);
        step(0, '0, 0, 0, '0, '0, 1, 32'hCAFEF00D);
        idle(0);
        chk("t2_if_rdata", if_rdata, 32'hCAFEF00D);

        // Memory holds off m_ready for five cycles.
        step(0, '0, 1, 0, 32'h200, '0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 0, 0, '0, '0, 0, $urandom);
            chk("t3_busy_wait", busy, 1);
            chk("t3_m_addr_wait", m_addr, 32'h200);
        end
        step(0, '0, 0, 0, '0, '0, 1, 32'h55AA55AA);
        idle(0);
        chk("t3_d_rvalid", d_rvalid, 1);
        chk("t3_d_rdata", d_rdata, 32'h55AA55AA);
        idle(0);
        chk("t3_d_rvalid_once", d_rvalid, 0);

        // Both requesters saturated: starve guard decides whether fetch ever wins.
        n_fetch = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 32'h300, 1, 0, 32'h400, '0, 1, $urandom);
            if (if_gnt) n_fetch++;
        end
        exp_fetch = GUARD ? 2 : 0;
        chk("t4_fetch_grants", n_fetch, exp_fetch);
        idle(1);
        idle(0);

        // Asynchronous reset in the middle of an access.
        step(0, '0, 1, 0, 32'h500, '0, 0, '0);
        step(0, '0, 0, 0, '0, '0, 0, '0);
        #2;
        rst_n   = 0;
        m_ready = 1;
        #1;
        chk("t5_m_rd_async", m_rd, 0);
        chk("t5_m_wr_async", m_wr, 0);
        chk("t5_busy_async", busy, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle(1);
        idle(1);
        chk("t5_no_stale_rvalid", d_rvalid, 0);
        step(1, 32'h600, 0, 0, '0, '0, 0, '0);
        chk("t5_if_gnt_after_rst", if_gnt, 1);
        step(0, '0, 0, 0, '0, '0, 1, 32'h13579BDF);
        idle(0);
        chk("t5_if_rvalid", if_rvalid, 1);

        // Random traffic; a requester keeps req low while its own access is outstanding.
        for (int i = 0; i < 400; i++) begin
            ir = ($urandom_range(0, 99) < 60);
            dr = ($urandom_range(0, 99) < 55);
            if (out_valid && !txn_d) ir = 0;
            if (out_valid && txn_d) dr = 0;
            step(ir, $urandom & 32'hFFFC, dr, 1'($urandom_range(0, 1)), $urandom & 32'hFFFC,
                 $urandom, $urandom_range(0, 2) == 0, $urandom);
        end
        idle(1);
        idle(0);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
